// File: rtl/bc_drain.sv
// Pops breadcrumb words from the buffer's read FIFO and shifts them out MSB-first
// on a framed serial link (sck/sdo/frame) toward Avoidance.
module bc_drain #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4,
    parameter int GAP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    input  logic             avoid_rdy,
    output logic             sck,
    output logic             sdo,
    output logic             frame,
    output logic             busy,
    output logic [15:0]      word_count
);

    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GCYC = (GAP * CLK_DIV > 0) ? GAP * CLK_DIV : 1;
    localparam int GW   = (GCYC > 1) ? $clog2(GCYC) : 1;

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
        $error("bc_drain: CLK_DIV must be even and >= 2");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("bc_drain: WIDTH must be >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sreg;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            fifo_rd_en <= 1'b0;
            sck        <= 1'b0;
            sdo        <= 1'b0;
            frame      <= 1'b0;
            busy       <= 1'b0;
            word_count <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && avoid_rdy) begin
                        state      <= ST_FETCH;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    sreg    <= fifo_dout;
                    sdo     <= fifo_dout[WIDTH-1];
                    frame   <= 1'b1;
                    sck     <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        sck     <= 1'b0;
                        if (bit_cnt == BW'(WIDTH - 1)) begin
                            word_count <= word_count + 16'd1;
                            frame      <= 1'b0;
                            sdo        <= 1'b0;
                            gap_cnt    <= '0;
                            if (GAP == 0) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else begin
                            // rotate so every bit stays observed; next bit is now the MSB
                            bit_cnt <= bit_cnt + 1'b1;
                            sreg    <= {sreg[WIDTH-2:0], sreg[WIDTH-1]};
                            sdo     <= sreg[WIDTH-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        sck     <= (div_cnt >= DW'(HALF - 1));
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GCYC - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bc_drain.sv
// Directed bench for bc_drain: cycle-exact frame/sck/sdo/rd_en/busy checks with defaults.
module tb_bc_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [15:0] fifo_dout = '0;
    logic        fifo_rd_en;
    logic        avoid_rdy = 1'b0;
    logic        sck, sdo, frame, busy;
    logic [15:0] word_count;

    int total = 0;
    int bad   = 0;

    // small FIFO model: initial block pushes, clocked process pops
    logic [15:0] mem [0:31];
    int push_cnt = 0;
    int pop_cnt  = 0;
    logic flush  = 1'b0;
    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (flush) pop_cnt <= push_cnt;
        else if (fifo_rd_en && push_cnt != pop_cnt) begin
            fifo_dout <= mem[pop_cnt[4:0]];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    always #5 clk = ~clk;

    bc_drain dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .avoid_rdy(avoid_rdy), .sck(sck), .sdo(sdo),
        .frame(frame), .busy(busy), .word_count(word_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[push_cnt[4:0]] = w;
        push_cnt = push_cnt + 1;
    endtask

    // returns the number of negedges until fifo_rd_en is seen (cycle 1 of a word)
    task automatic wait_rd(input string tag, input int max, output int n);
        n = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk({tag, "_rd_timeout"}, 0, 1);
    endtask

    // called just after the rd_en cycle; checks cycles 2..75 of the word
    task automatic check_word(input string tag, input logic [15:0] w,
                              input logic [15:0] wc_exp, input int drop_at);
        logic [15:0] rx;
        logic        prev_sck;
        logic [4:0]  exp_v;
        int          k, ph;
        rx = '0;
        prev_sck = 1'b0;
        for (int c = 2; c <= 75; c++) begin
            @(negedge clk);
            if (c >= 3 && c <= 66) begin
                k  = (c - 3) / 4;
                ph = (c - 3) % 4;
                exp_v = {1'b0, 1'b1, (ph >= 2) ? 1'b1 : 1'b0, w[15-k], 1'b1};
            end else begin
                exp_v = {1'b0, 1'b0, 1'b0, 1'b0, (c == 75) ? 1'b0 : 1'b1};
            end
            chk($sformatf("%s_c%0d{rd,fr,sck,sdo,busy}", tag, c),
                {27'd0, fifo_rd_en, frame, sck, sdo, busy}, {27'd0, exp_v});
            if (sck && !prev_sck) rx = {rx[14:0], sdo};
            prev_sck = sck;
            if (c == 2)  chk({tag, "_wc_before"}, word_count, wc_exp - 16'd1);
            if (c == 67) chk({tag, "_wc_after"}, word_count, wc_exp);
            if (c == drop_at) avoid_rdy = 1'b0;
        end
        chk({tag, "_rx"}, rx, w);
    endtask

    initial begin
        int n, cnt_rd, cnt_busy, cnt_fr;

        // 1: reset held 2 cycles with work pending
        avoid_rdy = 1'b1;
        push(16'hA5C3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rst_c%0d", i),
                {11'd0, fifo_rd_en, frame, sck, sdo, busy, word_count},
                32'd0);
        end
        rst = 1'b0;

        // 2: single word
        wait_rd("single", 5, n);
        chk("single_rd_lat", n, 1);
        check_word("single", 16'hA5C3, 16'd1, -1);

        // 3: back-to-back, 75-cycle period
        push(16'h0001); push(16'h8000); push(16'hFFFF);
        wait_rd("b2b0", 5, n);
        chk("b2b0_rd_lat", n, 1);
        check_word("b2b0", 16'h0001, 16'd2, -1);
        wait_rd("b2b1", 5, n);
        chk("b2b1_period", n, 1);
        check_word("b2b1", 16'h8000, 16'd3, -1);
        wait_rd("b2b2", 5, n);
        chk("b2b2_period", n, 1);
        check_word("b2b2", 16'hFFFF, 16'd4, -1);

        // 4: flow control
        avoid_rdy = 1'b0;
        push(16'h3C3C); push(16'h0FF0);
        cnt_rd = 0; cnt_busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fifo_rd_en) cnt_rd++;
            if (busy) cnt_busy++;
        end
        chk("fc_hold_rd", cnt_rd, 0);
        chk("fc_hold_busy", cnt_busy, 0);
        avoid_rdy = 1'b1;
        wait_rd("fc", 5, n);
        chk("fc_rd_lat", n, 1);
        check_word("fc", 16'h3C3C, 16'd5, 23);
        cnt_rd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_rd_en) cnt_rd++;
        end
        chk("fc_no_pop", cnt_rd, 0);
        chk("fc_left", push_cnt - pop_cnt, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;

        // 5: reset during bit 7 of the first word
        avoid_rdy = 1'b1;
        push(16'h1234); push(16'h5678);
        wait_rd("mid", 5, n);
        for (int c = 2; c <= 32; c++) @(negedge clk);
        chk("mid_frame_pre", frame, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_outs", {fifo_rd_en, frame, sck, sdo, busy}, 5'd0);
        chk("mid_rst_wc", word_count, 0);
        rst = 1'b0;
        wait_rd("mid2", 5, n);
        chk("mid2_rd_lat", n, 1);
        check_word("mid2", 16'h5678, 16'd1, -1);

        // 6: empty FIFO, ready receiver
        cnt_rd = 0; cnt_busy = 0; cnt_fr = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd_en) cnt_rd++;
            if (busy) cnt_busy++;
            if (frame) cnt_fr++;
        end
        chk("empty_rd", cnt_rd, 0);
        chk("empty_busy", cnt_busy, 0);
        chk("empty_frame", cnt_fr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
